// File: rtl/hall_pkg.sv
// hall_pkg: shared types and helpers for the hall quadrature decoder.
//   quad_state_t : filtered {hall_1, hall_2} level pair, one code per quadrant
//   step_dir_t   : classification of a transition between two quadrants
//   quad_decode  : classifies a prev -> curr quadrant transition
//   SYNC_STAGES  : flops between a raw hall pin and its glitch filter
package hall_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    // Encoded directly as {hall_1, hall_2} so a level pair casts straight in.
    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q10 = 2'b10,
        Q11 = 2'b11
    } quad_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CW   = 2'd1,
        CCW  = 2'd2,
        ERR  = 2'd3
    } step_dir_t;

    // Successor of a quadrant when turning clockwise (hall_1 leads).
    function automatic quad_state_t quad_next_cw(input quad_state_t s);
        quad_state_t nxt;
        case (s)
            Q00:     nxt = Q10;
            Q10:     nxt = Q11;
            Q11:     nxt = Q01;
            default: nxt = Q00;
        endcase
        return nxt;
    endfunction

    // Both bits flipping at once cannot be ordered, so it is reported as an error.
    function automatic step_dir_t quad_decode(input quad_state_t prev,
                                              input quad_state_t curr);
        step_dir_t dir;
        if (prev == curr) begin
            dir = NONE;
        end else if ((2'(prev) ^ 2'(curr)) == 2'b11) begin
            dir = ERR;
        end else if (quad_next_cw(prev) == curr) begin
            dir = CW;
        end else begin
            dir = CCW;
        end
        return dir;
    endfunction

endpackage

// File: rtl/hall_quadrature_decoder_if.sv
// hall_quadrature_decoder_if: pin and status bundle of the hall decoder.
//   hall_1_raw, hall_2_raw : raw asynchronous hall pins
//   hall_1, hall_2         : synchronised, filtered hall levels
//   clockwise              : direction of the last accepted step (1 = clockwise)
//   step, step_err         : one-cycle legal / illegal transition pulses
//   edge_period            : saturating clk count between the last two steps
//   stalled                : no step for 2^PERIOD_W-1 cycles
// Modports: master = decoder side, slave = sensor/consumer side.
interface hall_quadrature_decoder_if #(
    parameter int unsigned PERIOD_W = 16
);
    logic                hall_1_raw;
    logic                hall_2_raw;
    logic                hall_1;
    logic                hall_2;
    logic                clockwise;
    logic                step;
    logic                step_err;
    logic [PERIOD_W-1:0] edge_period;
    logic                stalled;

    modport master (
        input  hall_1_raw,
        input  hall_2_raw,
        output hall_1,
        output hall_2,
        output clockwise,
        output step,
        output step_err,
        output edge_period,
        output stalled
    );

    modport slave (
        output hall_1_raw,
        output hall_2_raw,
        input  hall_1,
        input  hall_2,
        input  clockwise,
        input  step,
        input  step_err,
        input  edge_period,
        input  stalled
    );

endinterface

// File: rtl/hall_glitch_filter.sv
// hall_glitch_filter: synchroniser plus persistence filter for one hall pin.
//   clk   : system clock
//   reset : synchronous active-low reset
//   raw   : asynchronous hall pin
//   level : filtered level; follows the synchronised pin only after it has
//           differed for FILTER_CYCLES consecutive cycles (legal 1..255)
module hall_glitch_filter
    import hall_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned        CNT_W    = 8;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = level_q;

    // Synchroniser shift chain and mismatch-run counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (synced == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // This cycle is the FILTER_CYCLES-th consecutive mismatch.
                level_q <= synced;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hall_quadrature_decoder.sv
// hall_quadrature_decoder: hall sensor front end for the angle tracker.
//   clk   : system clock, all state on the rising edge
//   reset : synchronous active-low reset
//   bus   : hall_quadrature_decoder_if.master (raw pins in; filtered levels,
//           direction, step/step_err pulses, edge_period, stalled out)
// Parameters: FILTER_CYCLES (filter persistence, 1..255), PERIOD_W (period width).
// Build option: HALL_REVERSAL_FILTER_EN -- when defined, clockwise only flips
// after two consecutive legal steps against the current direction.
module hall_quadrature_decoder
    import hall_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 8,
    parameter int unsigned PERIOD_W      = 16
) (
    input logic                       clk,
    input logic                       reset,
    hall_quadrature_decoder_if.master bus
);

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    logic                hall_1_f;
    logic                hall_2_f;
    quad_state_t         prev_q;
    quad_state_t         curr_c;
    step_dir_t           dir_c;
    logic                step_legal_c;
    logic                dir_is_cw_c;
    logic                cw_next_c;
    logic [PERIOD_W-1:0] period_inc_c;

    logic                clockwise_q;
    logic                step_q;
    logic                step_err_q;
    logic [PERIOD_W-1:0] period_cnt_q;
    logic [PERIOD_W-1:0] edge_period_q;
    logic                stalled_q;
`ifdef HALL_REVERSAL_FILTER_EN
    logic                rev_pending_q;
    logic                rev_pending_next_c;
`endif

    // One synchroniser + filter per channel.
    hall_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_1 (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.hall_1_raw),
        .level (hall_1_f)
    );

    hall_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_2 (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.hall_2_raw),
        .level (hall_2_f)
    );

    // Transition classification against last cycle's filtered pair.
    assign curr_c       = quad_state_t'({hall_1_f, hall_2_f});
    assign dir_c        = quad_decode(prev_q, curr_c);
    assign step_legal_c = (dir_c == CW) || (dir_c == CCW);
    assign dir_is_cw_c  = (dir_c == CW);

    // Saturating increment of the step-period counter.
    assign period_inc_c = (period_cnt_q == PERIOD_MAX) ? PERIOD_MAX
                                                       : period_cnt_q + PERIOD_W'(1);

    // Next direction; optionally debounced against single reversed steps.
    always_comb begin
        cw_next_c = clockwise_q;
`ifdef HALL_REVERSAL_FILTER_EN
        rev_pending_next_c = rev_pending_q;
        if (step_legal_c) begin
            if (dir_is_cw_c == clockwise_q) begin
                rev_pending_next_c = 1'b0;
            end else if (rev_pending_q) begin
                cw_next_c          = dir_is_cw_c;
                rev_pending_next_c = 1'b0;
            end else begin
                rev_pending_next_c = 1'b1;
            end
        end
`else
        if (step_legal_c) begin
            cw_next_c = dir_is_cw_c;
        end
`endif
    end

    // Decode, direction and period state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q        <= Q00;
            clockwise_q   <= 1'b1;
            step_q        <= 1'b0;
            step_err_q    <= 1'b0;
            period_cnt_q  <= '0;
            edge_period_q <= PERIOD_MAX;
            stalled_q     <= 1'b1;
`ifdef HALL_REVERSAL_FILTER_EN
            rev_pending_q <= 1'b0;
`endif
        end else begin
            prev_q      <= curr_c;
            step_q      <= step_legal_c;
            step_err_q  <= (dir_c == ERR);
            clockwise_q <= cw_next_c;
`ifdef HALL_REVERSAL_FILTER_EN
            rev_pending_q <= rev_pending_next_c;
`endif
            if (step_legal_c) begin
                period_cnt_q  <= '0;
                edge_period_q <= period_inc_c;
                stalled_q     <= 1'b0;
            end else begin
                period_cnt_q <= period_inc_c;
                // Sticky from reset until the first step.
                if (period_inc_c == PERIOD_MAX) begin
                    stalled_q <= 1'b1;
                end
            end
        end
    end

    assign bus.hall_1      = hall_1_f;
    assign bus.hall_2      = hall_2_f;
    assign bus.clockwise   = clockwise_q;
    assign bus.step        = step_q;
    assign bus.step_err    = step_err_q;
    assign bus.edge_period = edge_period_q;
    assign bus.stalled     = stalled_q;

endmodule

// File: tb/tb_hall_quadrature_decoder.sv
// tb_hall_quadrature_decoder: self-checking bench for hall_quadrature_decoder.
// Directed steps from the test plan, then random pin activity, then a long
// idle to reach saturation; every cycle is compared against a quadrant-index
// reference model. Honours HALL_REVERSAL_FILTER_EN when defined.
`timescale 1ns/1ps
module tb_hall_quadrature_decoder;

    localparam int unsigned FILTER_CYCLES = 8;
    localparam int unsigned PERIOD_W      = 16;
    localparam int          PMAX          = 65535;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hall_quadrature_decoder_if #(.PERIOD_W(PERIOD_W)) bus ();

    hall_quadrature_decoder #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .PERIOD_W      (PERIOD_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state; index 1 = hall_1, index 0 = hall_2.
    logic [1:0]  m_s0 = '0, m_s1 = '0, m_f = '0, m_prev = '0;
    int          m_run [2];
    logic        m_step = 0, m_err = 0, m_cw = 1, m_stalled = 1, m_seen = 0;
    logic [15:0] m_ep = 16'hFFFF;
    int          m_since = 0;
    int          m_opp = 0;
    logic        m_amb_pend = 0, m_ep_amb = 0;

    // Position of a quadrant along the clockwise sequence 00,10,11,01.
    function automatic int qidx(input logic [1:0] q);
        case (q)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        int d;
        logic [1:0] raw;
        raw = {bus.hall_1_raw, bus.hall_2_raw};
        if (!reset) begin
            m_s0 = '0; m_s1 = '0; m_f = '0; m_prev = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_step = 0; m_err = 0; m_cw = 1; m_stalled = 1; m_seen = 0;
            m_ep = 16'hFFFF; m_since = 0; m_opp = 0;
            m_amb_pend = 0; m_ep_amb = 0;
        end else begin
            d = (qidx(m_f) - qidx(m_prev) + 4) % 4;
            m_step = (d == 1) || (d == 3);
            m_err  = (d == 2);
            m_prev = m_f;
            m_since++;
            if (m_err) m_amb_pend = 1;
            if (m_step) begin
                m_ep = (m_since >= PMAX) ? 16'hFFFF : 16'(m_since);
                m_ep_amb = m_amb_pend;
                m_amb_pend = 0;
                m_since = 0;
                m_seen = 1;
                m_stalled = 0;
`ifdef HALL_REVERSAL_FILTER_EN
                if ((d == 1) == m_cw) m_opp = 0;
                else begin
                    m_opp++;
                    if (m_opp == 2) begin m_cw = (d == 1); m_opp = 0; end
                end
`else
                m_cw = (d == 1);
`endif
            end else begin
                m_stalled = !m_seen || (m_since >= PMAX);
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (m_s1[ch] != m_f[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == int'(FILTER_CYCLES)) begin
                        m_f[ch] = m_s1[ch];
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_s1 = m_s0;
            m_s0 = raw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("hall_1",    32'(bus.hall_1),    32'(m_f[1]));
        chk("hall_2",    32'(bus.hall_2),    32'(m_f[0]));
        chk("clockwise", 32'(bus.clockwise), 32'(m_cw));
        chk("step",      32'(bus.step),      32'(m_step));
        chk("step_err",  32'(bus.step_err),  32'(m_err));
        chk("stalled",   32'(bus.stalled),   32'(m_stalled));
        if (!m_ep_amb) chk("edge_period", 32'(bus.edge_period), 32'(m_ep));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int h1_at, st_at, nstep, nerr, nh2;
        logic seen;
        logic [1:0] cw_seq [4];
        logic [1:0] r;
        cw_seq[0] = 2'b10; cw_seq[1] = 2'b11; cw_seq[2] = 2'b01; cw_seq[3] = 2'b00;

        bus.hall_1_raw = 1'b0;
        bus.hall_2_raw = 1'b0;

        // Reset held three cycles.
        reset = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        chk("rst_hall_1",   32'(bus.hall_1),      32'd0);
        chk("rst_hall_2",   32'(bus.hall_2),      32'd0);
        chk("rst_cw",       32'(bus.clockwise),   32'd1);
        chk("rst_ep",       32'(bus.edge_period), 32'hFFFF);
        chk("rst_stalled",  32'(bus.stalled),     32'd1);
        chk("rst_step",     32'(bus.step),        32'd0);
        chk("rst_step_err", 32'(bus.step_err),    32'd0);

        // Clean edge latency on hall_1.
        bus.hall_1_raw = 1'b1;
        h1_at = -1; st_at = -1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (bus.hall_1 && h1_at < 0) h1_at = k;
            if (bus.step && st_at < 0) st_at = k;
        end
        chk("lat_hall_1", 32'(h1_at), 32'd10);
        chk("lat_step",   32'(st_at), 32'd11);
        chk("lat_cw",     32'(bus.clockwise), 32'd1);

        // Reset mid-rotation back to a clean 00 start.
        bus.hall_1_raw = 1'b0;
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;

        // Short glitch on hall_2 must be swallowed.
        nh2 = 0; nstep = 0; nerr = 0;
        bus.hall_2_raw = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k == 5) bus.hall_2_raw = 1'b0;
            cyc();
            nh2 += int'(bus.hall_2); nstep += int'(bus.step); nerr += int'(bus.step_err);
        end
        chk("glitch_hall_2", 32'(nh2),   32'd0);
        chk("glitch_step",   32'(nstep), 32'd0);
        chk("glitch_err",    32'(nerr),  32'd0);

        // Full clockwise revolution, edges 100 cycles apart.
        nstep = 0;
        for (int i = 0; i < 4; i++) begin
            {bus.hall_1_raw, bus.hall_2_raw} = cw_seq[i];
            for (int k = 0; k < 100; k++) begin
                cyc();
                nstep += int'(bus.step);
            end
            if (i >= 1) chk("cw_ep", 32'(bus.edge_period), 32'd100);
        end
        chk("cw_steps",   32'(nstep),          32'd4);
        chk("cw_dir",     32'(bus.clockwise),  32'd1);
        chk("cw_stalled", 32'(bus.stalled),    32'd0);

        // Both pins toggled together.
        nstep = 0; nerr = 0;
        bus.hall_1_raw = 1'b1; bus.hall_2_raw = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            nstep += int'(bus.step); nerr += int'(bus.step_err);
        end
        chk("dbl_err",  32'(nerr),          32'd1);
        chk("dbl_step", 32'(nstep),         32'd0);
        chk("dbl_cw",   32'(bus.clockwise), 32'd1);
        bus.hall_1_raw = 1'b0; bus.hall_2_raw = 1'b0;
        repeat (30) cyc();

        // Single counter-clockwise step, then a second one.
        seen = 1'b0;
        bus.hall_2_raw = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (bus.step) begin
                seen = 1'b1;
`ifdef HALL_REVERSAL_FILTER_EN
                chk("ccw1_cw", 32'(bus.clockwise), 32'd1);
`else
                chk("ccw1_cw", 32'(bus.clockwise), 32'd0);
`endif
            end
        end
        chk("ccw1_seen", 32'(seen), 32'd1);
        seen = 1'b0;
        bus.hall_1_raw = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (bus.step) begin
                seen = 1'b1;
                chk("ccw2_cw", 32'(bus.clockwise), 32'd0);
            end
        end
        chk("ccw2_seen", 32'(seen), 32'd1);

        // Random pin activity including glitches, double toggles and a reset.
        for (int it = 0; it < 150; it++) begin
            if (it == 75) begin
                reset = 1'b0;
                repeat (2) cyc();
                reset = 1'b1;
            end
            r = 2'($urandom_range(0, 3));
            {bus.hall_1_raw, bus.hall_2_raw} = r;
            repeat ($urandom_range(1, 30)) cyc();
        end

        // Settle, then idle long enough to saturate the period counter.
        {bus.hall_1_raw, bus.hall_2_raw} = m_f;
        repeat (40) cyc();
        {bus.hall_1_raw, bus.hall_2_raw} = m_f;
        repeat (65540) cyc();
        chk("stall_hi", 32'(bus.stalled), 32'd1);
        seen = 1'b0;
        bus.hall_1_raw = ~bus.hall_1_raw;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (bus.step) begin
                seen = 1'b1;
                chk("stall_ep_sat",  32'(bus.edge_period), 32'hFFFF);
                chk("stall_dropped", 32'(bus.stalled),     32'd0);
            end
        end
        chk("stall_step_seen", 32'(seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hall_quadrature_decoder.md
Name: hall_quadrature_decoder

Overview:
Front end for the hall sensor pair on the motor shaft, placed directly upstream of the angle tracking unit.
- Synchronises and glitch-filters the raw hall_1/hall_2 pins.
- Decodes the quadrature sequence into direction and step events, and measures the period between steps.
- Clean hall levels and clockwise feed the angle tracker; step, step_err and edge_period feed the speed and diagnostics logic.

Parameters:
FILTER_CYCLES, 8, consecutive stable cycles needed before a filtered hall level changes (legal range 1..255).
PERIOD_W, 16, width of the step-period counter and the edge_period output.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-low reset.
hall_1_raw  input  1  asynchronous hall sensor 1 pin.
hall_2_raw  input  1  asynchronous hall sensor 2 pin.
hall_1  output  1  synchronised, filtered hall 1 level.
hall_2  output  1  synchronised, filtered hall 2 level.
clockwise  output  1  direction of the most recent accepted step; 1 = clockwise.
step  output  1  one-cycle pulse per legal quadrature transition.
step_err  output  1  one-cycle pulse per illegal transition (both channels changed in the same cycle).
edge_period  output  PERIOD_W  clk cycles between the last two legal steps; saturating.
stalled  output  1  high while no step has occurred for 2^PERIOD_W-1 cycles.

Behaviour:
- Reset (reset == 0 sampled at a clk edge) clears all state:
  - synchroniser flops 0, filter counters 0;
  - hall_1 = 0, hall_2 = 0, clockwise = 1, step = 0, step_err = 0;
  - period counter = 0, edge_period = all ones, stalled = 1.
  - Reset mid-rotation discards any pending filter count; state is not otherwise preserved.
- Synchronisation: each raw pin passes through 2 flops before filtering.
- Filter, per channel:
  - While the synchronised value differs from the filtered output, the counter increments; any cycle where they match clears it to 0.
  - When the counter reaches FILTER_CYCLES, the output takes the new value and the counter clears.
  - Latency for a clean edge: raw change to filtered output change = FILTER_CYCLES + 2 cycles.
  - Pulses shorter than FILTER_CYCLES cycles never reach the outputs.
- Decode compares the previous and current filtered {hall_1, hall_2}:
  - Clockwise sequence: 00 -> 10 -> 11 -> 01 -> 00 (hall_1 leads). Matches the angle tracker's rule: hall_2 rising while hall_1 high means clockwise.
  - Counter-clockwise sequence: 00 -> 01 -> 11 -> 10 -> 00.
  - Legal transition: step = 1 for exactly one cycle, registered one cycle after the filtered change; clockwise updates in the same cycle.
  - Both bits changed: step_err = 1 for one cycle, no step, clockwise and period counter unchanged.
  - No change: no pulses.
- Period measurement:
  - Counter increments every cycle and saturates at 2^PERIOD_W-1.
  - On step: edge_period <= min(counter+1, max) and counter <= 0.
  - stalled = (counter == max); it drops on the next step.
- Back-to-back legal steps on consecutive cycles are each reported. The filter makes this unreachable in practice unless FILTER_CYCLES == 1.

Optional Feature:
HALL_REVERSAL_FILTER_EN
- Defined: clockwise flips only after 2 consecutive legal steps in the opposite direction. A single reversed step still pulses step and updates edge_period but leaves clockwise unchanged. A pending reversal is cancelled by any step in the current direction, and by reset.
- Undefined: clockwise follows every legal step immediately.

Decomposition:
- Package hall_pkg:
  - typedef quad_state_t (2-bit enum Q00, Q10, Q11, Q01);
  - typedef step_dir_t (NONE, CW, CCW, ERR);
  - function quad_decode(prev, curr) returning step_dir_t;
  - constant SYNC_STAGES = 2.
- Sub-module hall_glitch_filter (synchroniser + filter for one channel, parameter FILTER_CYCLES), instantiated twice.

Test Plan:
- Reset held 3 cycles then released -> hall_1 = hall_2 = 0, clockwise = 1, edge_period = 16'hFFFF, stalled = 1, no pulses.
- hall_1_raw goes high at cycle 0 with FILTER_CYCLES = 8 -> hall_1 rises at cycle 10; step at cycle 11; clockwise = 1.
- 5-cycle high glitch on hall_2_raw -> hall_2 stays 0, no step, no step_err.
- Full clockwise cycle 00, 10, 11, 01, 00, with edges spaced 100 cycles -> 4 step pulses, clockwise = 1, edge_period = 100 after the 2nd step onward, stalled = 0.
- Both raw pins toggled in the same cycle from 00 -> step_err pulses once, no step, clockwise unchanged.
- Counter-clockwise single step (00 -> 01) after clockwise rotation -> clockwise = 0 one cycle after the filtered change. With HALL_REVERSAL_FILTER_EN, clockwise stays 1 until the second CCW step (01 -> 11).
